// File: rtl/if_fetch_controller_pkg.sv
// Shared definitions for the IF-stage fetch controller: widths, reset PC,
// HALT encoding and the debug-visible FSM state codes.
package if_fetch_controller_pkg;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned STATE_W = 3;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [PC_W-1:0]    PC_STEP           = 32'd4;

  // Encodings are visible on o_state, so they are fixed values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } fetch_state_e;

  // States in which the PC drives instruction-memory reads.
  function automatic logic is_fetch_state(input fetch_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/if_fetch_controller_pc_reg.sv
// if_pc_reg: program-counter register.
// Ports:
//   i_clk, i_reset_n   clock, async active-low reset (PC -> RESET_PC)
//   i_clear            reload RESET_PC (leaving LOAD)
//   i_redirect(_pc)    load branch/jump target
//   i_stall            hold PC
//   i_advance          PC += 4
//   o_pc               current PC
// Priority: clear > redirect > stall > advance.
module if_pc_reg
  import if_fetch_controller_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_clear,
  input  logic            i_redirect,
  input  logic [PC_W-1:0] i_redirect_pc,
  input  logic            i_stall,
  input  logic            i_advance,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  // PC update; the +4 wraps naturally at 2^32.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc <= RESET_PC;
    end else if (i_clear) begin
      r_pc <= RESET_PC;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc;
    end else if (i_stall) begin
      r_pc <= r_pc;
    end else if (i_advance) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch_controller.sv
// if_fetch_controller: IF-stage sequencer. Owns the PC, shares the single
// instruction-memory port between the debug loader and fetch, applies
// stalls/redirects and stops on the HALT word.
// Ports:
//   loader : i_load_en/addr/data in, o_load_ack out (one cycle after a write)
//   control: i_run, i_step (IDLE only), i_stall, i_redirect/_pc (RUN/STEP only)
//   imem   : o_imem_addr/we/wdata out, i_imem_rdata in (1-cycle read latency)
//   IF/ID  : o_instruction, o_pc, o_pc_plus4, o_valid
//   debug  : o_halted, o_state
module if_fetch_controller
  import if_fetch_controller_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned        IMEM_AW   = 8,
  parameter logic [INSTR_W-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_load_en,
  input  logic [IMEM_AW-1:0] i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  output logic               o_load_ack,
  input  logic               i_run,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [PC_W-1:0]    i_redirect_pc,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic               o_imem_we,
  output logic [INSTR_W-1:0] o_imem_wdata,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instruction,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus4,
  output logic               o_valid,
  output logic               o_halted,
  output logic [STATE_W-1:0] o_state
);

  fetch_state_e       r_state;
  logic [PC_W-1:0]    r_fetch_pc;
  logic               r_valid_q;
  logic               r_load_ack;

  logic [PC_W-1:0]    w_pc;
  logic [IMEM_AW-1:0] w_imem_addr;
  logic               w_in_load;
  logic               w_fetching;
  logic               w_load_wr;
  logic               w_pc_clear;
  logic               w_redirect;
  logic               w_stall;
  logic               w_halt_det;
  logic               w_advance;

  assign w_in_load  = (r_state == ST_LOAD);
  assign w_fetching = is_fetch_state(r_state);
  assign w_load_wr  = w_in_load & i_load_en;
  assign w_pc_clear = w_in_load & ~i_load_en;
  assign w_redirect = w_fetching & i_redirect;
  assign w_stall    = w_fetching & i_stall & ~i_redirect;

  // HALT counts only for a live, non-stalled, non-squashed word in RUN.
  assign w_halt_det = (r_state == ST_RUN) & r_valid_q &
                      (i_imem_rdata == HALT_WORD) & ~i_stall & ~i_redirect;
  assign w_advance  = w_fetching & ~i_redirect & ~i_stall & ~w_halt_det;

  if_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_clear       (w_pc_clear),
    .i_redirect    (w_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_stall       (w_stall),
    .i_advance     (w_advance),
    .o_pc          (w_pc)
  );

  // Port mux. While stalled the held instruction's own address is re-read
  // so the synchronous memory keeps returning the same word.
  always_comb begin
    w_imem_addr = w_pc[IMEM_AW+1:2];
    if (w_in_load) begin
      w_imem_addr = i_load_addr;
    end else if (w_stall) begin
      w_imem_addr = r_fetch_pc[IMEM_AW+1:2];
    end
  end

  // Control FSM with fetch_pc / valid / load-ack registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_valid_q  <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= w_load_wr;
      case (r_state)
        ST_IDLE: begin
          r_valid_q <= 1'b0;
          if (i_load_en) begin
            r_state <= ST_LOAD;
          end else if (i_run) begin
            r_state <= ST_RUN;
          end else if (i_step) begin
            r_state <= ST_STEP;
          end
        end
        ST_LOAD: begin
          r_valid_q <= 1'b0;
          if (!i_load_en) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (w_redirect) begin
            r_valid_q <= 1'b0;
          end else if (!i_stall) begin
            if (w_halt_det) begin
              r_valid_q <= 1'b0;
              r_state   <= ST_HALT;
            end else begin
              r_fetch_pc <= w_pc;
              r_valid_q  <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (w_redirect) begin
            r_valid_q <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (!i_stall) begin
            r_fetch_pc <= w_pc;
            r_valid_q  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        ST_HALT: begin
          r_valid_q <= 1'b0;
          if (i_load_en) begin
            r_state <= ST_LOAD;
          end
        end
        default: begin
          r_valid_q <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_imem_addr   = w_imem_addr;
  assign o_imem_we     = w_load_wr;
  assign o_imem_wdata  = w_in_load ? i_load_data : '0;
  assign o_load_ack    = r_load_ack;
  assign o_instruction = r_valid_q ? i_imem_rdata : '0;
  assign o_pc          = r_fetch_pc;
  assign o_pc_plus4    = r_fetch_pc + PC_STEP;
  assign o_valid       = r_valid_q;
  assign o_halted      = (r_state == ST_HALT);
  assign o_state       = r_state;

endmodule

// File: tb/tb_if_fetch_controller.sv
// Bench for if_fetch_controller: directed scenarios plus random traffic,
// every cycle compared against a behavioural fetch model.
module tb_if_fetch_controller;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam logic [31:0] RSTPC = 32'h0000_0000;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_load_en = 1'b0;
  logic [AW-1:0] i_load_addr = '0;
  logic [31:0]   i_load_data = '0;
  logic          i_run = 1'b0, i_step = 1'b0, i_stall = 1'b0, i_redirect = 1'b0;
  logic [31:0]   i_redirect_pc = '0;
  logic [31:0]   imem_rdata;

  logic          o_load_ack, o_imem_we, o_valid, o_halted;
  logic [AW-1:0] o_imem_addr;
  logic [31:0]   o_imem_wdata, o_instruction, o_pc, o_pc_plus4;
  logic [2:0]    o_state;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int ack_cnt = 0;
  logic [31:0] vlog [$];
  logic [31:0] prog [32];

  always #5 clk = ~clk;

  if_fetch_controller dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .o_load_ack    (o_load_ack),
    .i_run         (i_run),
    .i_step        (i_step),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_addr   (o_imem_addr),
    .o_imem_we     (o_imem_we),
    .o_imem_wdata  (o_imem_wdata),
    .i_imem_rdata  (imem_rdata),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .o_valid       (o_valid),
    .o_halted      (o_halted),
    .o_state       (o_state)
  );

  // Synchronous-read instruction memory.
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (o_imem_we) mem[o_imem_addr] <= o_imem_wdata;
    imem_rdata <= mem[o_imem_addr];
  end

  // Behavioural model: run mode, next PC to fetch, the instruction being
  // presented (pc + live flag), and a shadow copy of program memory.
  logic [31:0] m_mem [DEPTH];
  int          m_mode;
  logic [31:0] m_pc, m_opc;
  logic        m_valid, m_ack;

  function automatic logic [31:0] m_word(input logic [31:0] pc);
    return m_mem[(pc >> 2) % DEPTH];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_pc <= RSTPC; m_opc <= RSTPC;
      m_valid <= 1'b0; m_ack <= 1'b0;
    end else begin
      m_ack <= (m_mode == M_LOAD) && i_load_en;
      case (m_mode)
        M_IDLE: begin
          m_valid <= 1'b0;
          if (i_load_en) m_mode <= M_LOAD;
          else if (i_run) m_mode <= M_RUN;
          else if (i_step) m_mode <= M_STEP;
        end
        M_LOAD: begin
          m_valid <= 1'b0;
          if (i_load_en) m_mem[i_load_addr] <= i_load_data;
          else begin m_mode <= M_IDLE; m_pc <= RSTPC; end
        end
        M_RUN, M_STEP: begin
          if (i_redirect) begin
            m_pc <= i_redirect_pc; m_valid <= 1'b0;
            if (m_mode == M_STEP) m_mode <= M_IDLE;
          end else if (!i_stall) begin
            if (m_mode == M_RUN && m_valid && m_word(m_opc) == HALT) begin
              m_mode <= M_HALT; m_valid <= 1'b0;
            end else begin
              m_opc <= m_pc; m_pc <= m_pc + 32'd4; m_valid <= 1'b1;
              if (m_mode == M_STEP) m_mode <= M_IDLE;
            end
          end
        end
        default: begin
          m_valid <= 1'b0;
          if (i_load_en) m_mode <= M_LOAD;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("state", 32'(o_state), 32'(m_mode));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("halted", 32'(o_halted), 32'(m_mode == M_HALT));
    chk("load_ack", 32'(o_load_ack), 32'(m_ack));
    chk("imem_we", 32'(o_imem_we), 32'((m_mode == M_LOAD) && i_load_en));
    if ((m_mode == M_LOAD) && i_load_en) begin
      chk("imem_addr", 32'(o_imem_addr), 32'(i_load_addr));
      chk("imem_wdata", o_imem_wdata, i_load_data);
    end
    if (m_valid) begin
      chk("pc", o_pc, m_opc);
      chk("pc_plus4", o_pc_plus4, m_opc + 32'd4);
      chk("instruction", o_instruction, m_word(m_opc));
    end else begin
      chk("instruction_idle", o_instruction, 32'h0);
    end
    if (o_valid) vlog.push_back(o_pc);
    if (o_imem_we) we_cnt++;
    if (o_load_ack) ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] getv(input int k);
    if (k < vlog.size()) return vlog[k];
    return 32'hDEAD_BEEF;
  endfunction

  // Entry cycle in IDLE/HALT, then one write per LOAD cycle, then exit.
  task automatic load_block(input int n);
    i_load_en = 1'b1; i_load_addr = '0; i_load_data = prog[0];
    tick();
    for (int k = 0; k < n; k++) begin
      i_load_addr = AW'(k); i_load_data = prog[k];
      tick();
    end
    i_load_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bit found;
    int n4;
    logic [31:0] tgt;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] <= 32'h0;
      m_mem[i] <= 32'h0;
    end
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_ack", 32'(o_load_ack), 32'd0);
    chk("rst_we", 32'(o_imem_we), 32'd0);
    rst_n = 1'b1;
    tick();

    // Program A: two addi, nop, HALT.
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0003;
    prog[2] = 32'h0000_0000; prog[3] = HALT;
    we_cnt = 0; ack_cnt = 0;
    load_block(4);
    chk("load_we_cycles", 32'(we_cnt), 32'd4);
    chk("load_ack_pulses", 32'(ack_cnt), 32'd4);
    chk("load_back_idle", 32'(o_state), 32'd0);

    vlog.delete();
    i_run = 1'b1; tick(); i_run = 1'b0;
    repeat (7) tick();
    chk("run_count", 32'(vlog.size()), 32'd4);
    chk("run_pc0", getv(0), 32'h0);
    chk("run_pc1", getv(1), 32'h4);
    chk("run_pc2", getv(2), 32'h8);
    chk("run_pc3", getv(3), 32'hC);
    chk("run_halted", 32'(o_halted), 32'd1);

    // Program B: same head, filler, HALT at word 20 (0x50).
    for (int k = 3; k < 32; k++) begin
      prog[k] = $urandom;
      if (prog[k] == HALT) prog[k] = 32'h1234_5678;
    end
    prog[20] = HALT;
    load_block(32);

    vlog.delete();
    i_run = 1'b1; tick(); i_run = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_valid && o_pc == 32'h4) begin found = 1'b1; break; end
      tick();
    end
    chk("stall_reach_pc4", 32'(found), 32'd1);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold_instr", o_instruction, 32'h2002_0003);
    end
    i_stall = 1'b0;
    repeat (3) tick();
    n4 = 0;
    foreach (vlog[k]) if (vlog[k] == 32'h4) n4++;
    chk("stall_pc4_cycles", 32'(n4), 32'd4);
    chk("stall_first", getv(0), 32'h0);
    chk("stall_after", getv(5), 32'h8);
    chk("stall_after2", getv(6), 32'hC);

    // Redirect with a simultaneous stall: redirect wins.
    i_redirect = 1'b1; i_redirect_pc = 32'h40; i_stall = 1'b1;
    tick();
    i_redirect = 1'b0; i_stall = 1'b0;
    chk("redir_bubble", 32'(o_valid), 32'd0);
    tick();
    chk("redir_valid", 32'(o_valid), 32'd1);
    chk("redir_pc", o_pc, 32'h40);
    chk("redir_instr", o_instruction, prog[16]);

    // HALT word squashed by a redirect in the same cycle.
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (o_valid && o_instruction == HALT) begin
        found = 1'b1;
        i_redirect = 1'b1; i_redirect_pc = 32'h10;
        tick();
        i_redirect = 1'b0;
        tick();
        break;
      end
      tick();
    end
    chk("halt_seen", 32'(found), 32'd1);
    chk("halt_squashed", 32'(o_halted), 32'd0);
    chk("halt_redir_pc", o_pc, 32'h10);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_halted) begin found = 1'b1; break; end
      tick();
    end
    chk("halt_reached", 32'(found), 32'd1);

    // HALT ignores run/step; only load leaves it.
    i_run = 1'b1; i_step = 1'b1; tick(); i_run = 1'b0; i_step = 1'b0;
    tick();
    chk("halt_sticky", 32'(o_state), 32'd4);
    i_load_en = 1'b1; tick(); i_load_en = 1'b0; tick();
    chk("halt_exit_idle", 32'(o_state), 32'd0);

    // Single step from IDLE.
    vlog.delete();
    i_step = 1'b1; tick(); i_step = 1'b0;
    repeat (3) tick();
    chk("step_pulses", 32'(vlog.size()), 32'd1);
    chk("step_pc", getv(0), 32'h0);
    chk("step_idle", 32'(o_state), 32'd0);

    // Random traffic, including PC wrap at the memory depth and at 2^32.
    for (int c = 0; c < 2500; c++) begin
      i_run      = ($urandom % 10) == 0;
      i_step     = ($urandom % 8) == 0;
      i_stall    = ($urandom % 4) == 0;
      i_redirect = ($urandom % 12) == 0;
      case ($urandom % 8)
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = 32'h0000_03FC;
        default: tgt = 32'(($urandom % 32) * 4);
      endcase
      i_redirect_pc = tgt;
      if (o_state == 3'd1) i_load_en = ($urandom % 4) != 0;
      else                 i_load_en = ($urandom % 30) == 0;
      i_load_addr = AW'($urandom % 32);
      i_load_data = (($urandom % 6) == 0) ? HALT : $urandom;
      tick();
    end
    i_run = 1'b0; i_step = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_load_en = 1'b0;

    // Reset in the middle of a load aborts the write at once.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    i_load_en = 1'b1; i_load_addr = AW'(5); i_load_data = 32'h0000_1234;
    tick();
    tick();
    chk("midload_we_high", 32'(o_imem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midload_we_drop", 32'(o_imem_we), 32'd0);
    chk("midload_state", 32'(o_state), 32'd0);
    chk("midload_ack", 32'(o_load_ack), 32'd0);
    chk("midload_valid", 32'(o_valid), 32'd0);
    chk("midload_instr", o_instruction, 32'h0);
    chk("midload_halted", 32'(o_halted), 32'd0);
    i_load_en = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_controller.md
Name: if_fetch_controller

Overview:
- Sequences the IF stage of the MIPS pipeline. Owns the PC register and arbitrates the single instruction-memory port between the debug loader (writes) and instruction fetch (reads).
- Applies hazard-unit stalls and ID-stage branch/jump redirects.
- Detects the HALT word and reports run state to the debug unit.
- Sits between the debug unit, the synchronous-read instruction memory and the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset and after leaving LOAD
IMEM_AW, 8, instruction-memory word-address width (depth 2^IMEM_AW words)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous, active-low reset
i_load_en  in  1  loader write request (valid with addr/data)
i_load_addr  in  IMEM_AW  loader word address
i_load_data  in  32  loader write data
o_load_ack  out  1  registered; high the cycle after each accepted write
i_run  in  1  start free-running fetch (level, sampled in IDLE)
i_step  in  1  single-fetch request (sampled in IDLE)
i_stall  in  1  hazard-unit stall: hold PC and IF output
i_redirect  in  1  branch/jump taken in ID
i_redirect_pc  in  32  redirect target
o_imem_addr  out  IMEM_AW  memory word address
o_imem_we  out  1  memory write enable
o_imem_wdata  out  32  memory write data
i_imem_rdata  in  32  memory read data, 1-cycle synchronous latency
o_instruction  out  32  i_imem_rdata when o_valid, else 0
o_pc  out  32  byte address of o_instruction
o_pc_plus4  out  32  o_pc + 4
o_valid  out  1  o_instruction is a live fetch
o_halted  out  1  state == HALT
o_state  out  3  encoded FSM state for debug

Behaviour:
- States: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- Reset (asynchronous, any state):
  - state=IDLE; pc=RESET_PC; fetch_pc=RESET_PC; valid_q=0.
  - o_load_ack=0, o_valid=0, o_instruction=0, o_halted=0.
  - o_imem_we=0 immediately, so an in-flight write is aborted.
- IDLE:
  - i_load_en -> LOAD, else i_run -> RUN, else i_step -> STEP (priority load > run > step).
  - No fetch; valid_q=0.
- LOAD:
  - o_imem_we = i_load_en, combinational. o_imem_addr=i_load_addr, o_imem_wdata=i_load_data.
  - o_load_ack registered copy of the accepted write.
  - i_load_en low -> IDLE, pc<=RESET_PC.
- Fetch (RUN/STEP):
  - o_imem_addr = pc[IMEM_AW+1:2]; o_imem_we=0.
  - Per-cycle priority: redirect > stall > advance.
    - redirect: pc<=i_redirect_pc; valid_q<=0 (wrong-path fetch squashed, one bubble); state unchanged.
    - stall (no redirect): pc, fetch_pc, valid_q hold. The address is re-read, so o_instruction stays stable.
    - advance: fetch_pc<=pc; pc<=pc+4 (mod 2^32; memory index wraps at 2^IMEM_AW); valid_q<=1.
  - o_valid = valid_q. o_pc = fetch_pc. Latency: address issued cycle N, instruction valid cycle N+1.
- RUN: i_load_en ignored. Transitions to HALT on o_valid && o_instruction==HALT_WORD && !i_stall && !i_redirect:
  - The HALT word is presented once with o_valid=1.
  - Next cycle: state=HALT, valid_q=0, pc frozen.
  - A redirect in the detection cycle wins: the HALT is wrong-path and is ignored.
- STEP:
  - Issues exactly one advance, then -> IDLE; o_valid is high for exactly one cycle.
  - Stall holds STEP until it clears.
  - Redirect in STEP consumes the step: pc<=target, no valid, -> IDLE.
- HALT:
  - o_halted=1, o_valid=0.
  - Only i_load_en leaves it (-> LOAD); i_run and i_step are ignored.
- i_stall and i_redirect are ignored outside RUN/STEP.

Decomposition:
- Shared package: state encodings, HALT_WORD, RESET_PC, PC width 32.
- One natural sub-module, if_pc_reg: PC register with redirect > stall > increment priority and async active-low reset. The FSM and port mux stay in the top.

Test Plan:
- Load 4 words at addresses 0..3 (0x20010005, 0x20020003, 0x00000000, 0xFFFFFFFF) -> o_imem_we high 4 cycles, 4 o_load_ack pulses each one cycle late, then IDLE with pc=0.
- i_run after the load -> o_pc 0,4,8,12 on consecutive cycles with o_valid=1 and matching words; o_halted rises the cycle after o_pc=12; pc frozen.
- Stall 3 cycles during RUN at o_pc=4 -> o_pc=4 and o_instruction=0x20020003 held 3 extra cycles; no skipped or duplicated PCs after release.
- i_redirect to 0x40 in the same cycle as i_stall -> next cycle o_valid=0, following cycle o_pc=0x40 valid; stall ignored.
- HALT_WORD fetched with simultaneous i_redirect -> no halt; fetch continues at the target.
- i_step from IDLE -> exactly one o_valid pulse, then IDLE. i_reset_n low mid-load with i_load_en high -> o_imem_we drops immediately; all outputs at reset values.
